// File: rtl/mult_div_sequencer.sv
// Sequential MULT/MULTU/DIV/DIVU controller for the HI/LO unit.
// All arithmetic goes through one shared 65-bit adder; fixed 37-cycle latency.

module adder65 (
    input  logic [64:0] x,
    input  logic [64:0] y,
    input  logic        cin,
    output logic [64:0] sum
);
    assign sum = x + y + {64'b0, cin};
endmodule

module mult_div_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, ITER, FIX_LO, FIX_HI} state_t;

    state_t      state, state_n;
    logic [1:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] mag_a, mag_b;
    logic [32:0] acc;     // multiply accumulator / divide remainder
    logic [31:0] lo_w;    // multiplier / quotient
    logic [4:0]  cnt;

    logic [64:0] add_x, add_y, add_sum, fix_v;
    logic        add_cin, fix_neg;

    wire is_div    = op_r[1];
    wire is_signed = op_r[0];
    wire [32:0] rem_s = {acc[31:0], lo_w[31]};

    adder65 u_add (.x(add_x), .y(add_y), .cin(add_cin), .sum(add_sum));

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        fix_v   = '0;
        fix_neg = 1'b0;
        case (state)
            IDLE: if (start) state_n = ABS_A;
            ABS_A: begin
                fix_v   = {33'b0, a_r};
                fix_neg = is_signed && a_r[31];
                add_x   = fix_neg ? ~fix_v : fix_v;
                add_cin = fix_neg;
                state_n = ABS_B;
            end
            ABS_B: begin
                fix_v   = {33'b0, b_r};
                fix_neg = is_signed && b_r[31];
                add_x   = fix_neg ? ~fix_v : fix_v;
                add_cin = fix_neg;
                state_n = ITER;
            end
            ITER: begin
                if (is_div) begin
                    // Trial subtraction; bit 64 set means the divisor did not fit.
                    add_x   = {32'b0, rem_s};
                    add_y   = ~{33'b0, mag_b};
                    add_cin = 1'b1;
                end else begin
                    add_x = {32'b0, acc};
                    add_y = lo_w[0] ? {33'b0, mag_a} : '0;
                end
                if (cnt == 5'd31) state_n = FIX_LO;
            end
            FIX_LO: begin
                fix_v   = is_div ? {33'b0, lo_w} : {1'b0, acc[31:0], lo_w};
                fix_neg = is_signed && (a_r[31] ^ b_r[31]);
                add_x   = fix_neg ? ~fix_v : fix_v;
                add_cin = fix_neg;
                state_n = FIX_HI;
            end
            FIX_HI: begin
                fix_v   = {32'b0, acc};
                fix_neg = is_div && is_signed && a_r[31];
                add_x   = fix_neg ? ~fix_v : fix_v;
                add_cin = fix_neg;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc         <= '0;
            lo_w        <= '0;
            cnt         <= '0;
        end else begin
            state <= state_n;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_r <= op;
                    a_r  <= a;
                    b_r  <= b;
                end
                ABS_A: mag_a <= add_sum[31:0];
                ABS_B: begin
                    mag_b <= add_sum[31:0];
                    cnt   <= '0;
                    acc   <= '0;
                    lo_w  <= is_div ? mag_a : add_sum[31:0];
                end
                ITER: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        if (!add_sum[64]) begin
                            acc  <= add_sum[32:0];
                            lo_w <= {lo_w[30:0], 1'b1};
                        end else begin
                            acc  <= rem_s;
                            lo_w <= {lo_w[30:0], 1'b0};
                        end
                    end else begin
                        acc  <= {1'b0, add_sum[32:1]};
                        lo_w <= {add_sum[0], lo_w[31:1]};
                    end
                end
                FIX_LO: begin
                    if (is_div) lo_w <= add_sum[31:0];
                    else {acc[31:0], lo_w} <= add_sum[63:0];
                end
                FIX_HI: begin
                    hi          <= add_sum[31:0];
                    lo          <= lo_w;
                    done        <= 1'b1;
                    div_by_zero <= is_div && (b_r == 32'd0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: directed vectors, decoupled monitor.
// Handshake: start is sampled on a rising edge only while busy=0; done pulses one cycle with results.

module tb_mult_div_sequencer;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  logic [64:0] exp_q[$];
  int          exp_cyc_q[$];

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  mult_div_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // monitor: pops an expectation on every done pulse
  initial begin
    logic [64:0] e;
    int ec;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result{dbz,hi,lo}", {div_by_zero, hi, lo}, e);
          check("done_cycle", 65'(cyc), 65'(ec));
          check("busy_at_done", {64'b0, busy}, 65'd0);
        end
      end
    end
  end

  // driver: waits for idle, pulses start, optionally records the expected result
  task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edbz);
    int t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles expected busy=0", t);
      return;
    end
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk);
    last_start = cyc + 1;
    if (push) begin
      exp_q.push_back({edbz, ehi, elo});
      exp_cyc_q.push_back(last_start + 36);
    end
    @(negedge clk);
    start = 1'b0;
    op = $urandom_range(0, 3);
    a = $urandom;
    b = $urandom;
    check("busy_after_start", {64'b0, busy}, 65'd1);
  endtask

  initial begin
    int first_start;
    int t;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs{busy,done,dbz}", {62'b0, busy, done, div_by_zero}, 65'd0);
    check("reset_hilo", {1'b0, hi, lo}, 65'd0);
    check("reset_state", {62'b0, dbg_state}, 65'd0);
    reset = 1'b0;

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    issue(MULT,  32'hFFFFFFFD, 32'd7,        1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    issue(DIV,   32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    issue(DIVU,  32'h12345678, 32'd0,        1, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    issue(DIV,   32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 1'b0);
    issue(DIV,   32'hFFFFFFF9, 32'd0,        1, 32'hFFFFFFF9, 32'h00000001, 1'b1);
    issue(DIV,   32'd7,        32'hFFFFFFFE, 1, 32'h00000001, 32'hFFFFFFFD, 1'b0);

    // back-to-back with an ignored start during the first op
    issue(MULTU, 32'd6, 32'd7, 1, 32'd0, 32'd42, 1'b0);
    first_start = last_start;
    repeat (4) @(negedge clk);
    start = 1'b1; op = DIVU; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    issue(DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0);
    check("back_to_back_start_cycle", 65'(last_start), 65'(first_start + 37));

    // drain
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 65'(exp_q.size()), 65'd0);

    // reset in cycle 10 aborts the op: no done, outputs cleared
    issue(MULTU, 32'd3, 32'd5, 0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy_done", {63'b0, busy, done}, 65'd0);
    check("abort_hilo", {div_by_zero, hi, lo}, 65'd0);
    repeat (40) @(negedge clk);
    check("abort_still_idle", {64'b0, busy}, 65'd0);

    // reset and start together: start dropped
    reset = 1'b1; start = 1'b1; op = MULTU; a = 32'd2; b = 32'd2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset_wins_busy", {64'b0, busy}, 65'd0);
    repeat (3) @(negedge clk);
    check("reset_wins_idle", {62'b0, dbg_state}, 65'd0);

    // recovery after reset
    issue(MULT, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 1'b0);
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("final_queue_empty", 65'(exp_q.size()), 65'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
